// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame FSM encoding and line idle level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic RX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line; resets to the idle (high) level
// so that reset release never looks like a start-bit edge.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RX_IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_rx};
        end
    end

    assign o_rx_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detection, bit sampling on external en ticks,
// LSB-first assembly and valid/ready delivery. Optional parity check: UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 en,
    output logic                 count_en,
    output logic                 half_full,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 w_rx_s;
    logic                 w_fall;
    logic                 w_last_bit;

    rx_state_t            r_state;
    logic                 r_rx_prev;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_count_en;
    logic                 r_half_full;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_rx  (rx),
        .o_rx_s(w_rx_s)
    );

    assign w_fall     = r_rx_prev & ~w_rx_s;
    assign w_last_bit = (r_bit_cnt == CNT_W'(DATA_BITS - 1));

`ifdef UART_RX_PARITY_EN
    logic w_par_exp;
    logic r_par_err;
    logic r_parity_err;

    assign w_par_exp = (^r_shift) ^ (PARITY_ODD != 0);
`endif

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rx_prev   <= RX_IDLE_LEVEL;
            r_bit_cnt   <= '0;
            // NOTE: the shift register is reset too, so an aborted frame leaves no residue.
            r_shift     <= '0;
            r_count_en  <= 1'b0;
            r_half_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_prev   <= w_rx_s;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // NOTE: a word loaded in STOP below overrides this clear; the last assignment wins.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_count_en  <= 1'b0;
                    r_half_full <= 1'b0;
                    if (w_fall) begin
                        r_state     <= START;
                        r_count_en  <= 1'b1;
                        r_half_full <= 1'b1;
                    end
                end
                START: begin
                    if (en) begin
`ifdef UART_RX_PARITY_EN
                        r_par_err <= 1'b0;
`endif
                        if (!w_rx_s) begin
                            r_state     <= DATA;
                            r_half_full <= 1'b0;
                            r_bit_cnt   <= '0;
                        end else begin
                            r_state     <= IDLE;
                            r_count_en  <= 1'b0;
                            r_half_full <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (en) begin
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        if (w_last_bit) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (en) begin
                        r_par_err <= (w_rx_s != w_par_exp);
                        r_state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (en) begin
                        r_state     <= IDLE;
                        r_count_en  <= 1'b0;
                        r_half_full <= 1'b0;
                        if (!w_rx_s) begin
                            r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (r_par_err) begin
                            r_parity_err <= 1'b1;
`endif
                        end else if (r_rx_valid && !rx_ready) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_count_en <= 1'b0;
                end
            endcase
        end
    end

    assign count_en  = r_count_en;
    assign half_full = r_half_full;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
